// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

    localparam logic [1:0] ADDR_TX_DATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_EMPTY = 3;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous first-word-fall-through FIFO; the head is always visible on dout.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                mem[gi] <= din;
            end
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus writes queue bytes in a FIFO,
// a single FSM serialises them LSB first onto a registered line.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  uart_tx_out,
    output logic                  tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_tx_state_t state_reg;
    logic [CW-1:0]  cnt_reg;
    logic [2:0]     bit_idx_reg;
    logic [7:0]     shift_reg;
    logic           line_reg;
    logic           ovf_reg;

    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           wr_tx_data;
    logic           wr_status;
    logic           cnt_last;
    logic           unused_wdata;

    assign unused_wdata = ^wdata[DATA_WIDTH-1:8];

    assign wr_tx_data = we && (addr == ADDR_TX_DATA);
    assign wr_status  = we && (addr == ADDR_STATUS);
    assign fifo_pop   = (state_reg == TX_IDLE) && !fifo_empty;
    assign cnt_last   = (cnt_reg == CNT_LAST);

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (wr_tx_data),
        .pop  (fifo_pop),
        .din  (wdata[7:0]),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= TX_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            line_reg    <= 1'b1;
        end else begin
            case (state_reg)
                TX_IDLE: begin
                    line_reg <= 1'b1;
                    if (fifo_pop) begin
                        shift_reg <= fifo_dout;
                        cnt_reg   <= '0;
                        line_reg  <= 1'b0;
                        state_reg <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt_last) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        line_reg    <= shift_reg[0];
                        state_reg   <= TX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (cnt_last) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            line_reg  <= 1'b1;
                            state_reg <= TX_STOP;
                        end else begin
                            // Line takes the next bit as the shifter advances.
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            line_reg    <= shift_reg[1];
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                TX_STOP: begin
                    line_reg <= 1'b1;
                    if (cnt_last) begin
                        cnt_reg   <= '0;
                        state_reg <= TX_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= TX_IDLE;
                end
            endcase
        end
    end

    // A push into a full FIFO is lost unless the FSM pops in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (wr_status) begin
            ovf_reg <= 1'b0;
        end else if (wr_tx_data && fifo_full && !fifo_pop) begin
            ovf_reg <= 1'b1;
        end
    end

    assign uart_tx_out = line_reg;
    assign tx_busy     = (state_reg != TX_IDLE) || !fifo_empty;

    always_comb begin
        rdata = '0;
        if (addr == ADDR_STATUS) begin
            rdata[ST_BUSY]  = tx_busy;
            rdata[ST_FULL]  = fifo_full;
            rdata[ST_OVF]   = ovf_reg;
            rdata[ST_EMPTY] = fifo_empty;
        end
    end

endmodule
